// File: rtl/fix_checksum.sv
// fix_checksum: running mod-256 FIX checksum, trailing "<SOH>10=ddd<SOH>" parse and compare.
// Latency: chk_done_o/valid_o/calc_o are registered and appear one cycle after the terminating byte.
// Backpressure: none; one byte per cycle is accepted whenever byte_valid_i is high.
//
// Ports:
//   clk, rst          - core clock, asynchronous active-low reset
//   byte_valid_i      - byte_i/start_i are accepted on this rising edge
//   byte_i, start_i   - stream byte and first-byte-of-message marker
//   chk_done_o        - one-cycle pulse ending a checksum evaluation
//   valid_o           - checksum matched (only while chk_done_o is high)
//   calc_o            - sum snapshot taken at the SOH leading the "10=" field
module fix_checksum #(
   parameter logic [7:0] SOH = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_i,
   input  logic       start_i,
   output logic       chk_done_o,
   output logic       valid_o,
   output logic [7:0] calc_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BODY     = 3'd1,
      SOH_SEEN = 3'd2,
      GOT1     = 3'd3,
      GOT10    = 3'd4,
      DIG      = 3'd5,
      TERM     = 3'd6
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  sum, sum_nxt;
   logic [7:0]  soh_sum, soh_sum_nxt;
   logic [9:0]  recv, recv_nxt;
   logic [1:0]  ndig, ndig_nxt;
   logic        done_q, done_nxt;
   logic        pass_q, pass_nxt;
   logic [7:0]  calc_q, calc_nxt;

   logic [7:0]  sum_add;
   logic        is_digit;
   logic [9:0]  digit_val;
   logic        msg_end;
   logic        msg_pass;

   assign sum_add   = sum + byte_i;
   assign is_digit  = (byte_i >= 8'h30) && (byte_i <= 8'h39);
   assign digit_val = {6'd0, byte_i[3:0]};

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sum     <= 8'd0;
         soh_sum <= 8'd0;
         recv    <= 10'd0;
         ndig    <= 2'd0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         calc_q  <= 8'd0;
      end else begin
         state   <= state_nxt;
         sum     <= sum_nxt;
         soh_sum <= soh_sum_nxt;
         recv    <= recv_nxt;
         ndig    <= ndig_nxt;
         done_q  <= done_nxt;
         pass_q  <= pass_nxt;
         calc_q  <= calc_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt   = state;
      sum_nxt     = sum;
      soh_sum_nxt = soh_sum;
      recv_nxt    = recv;
      ndig_nxt    = ndig;
      done_nxt    = 1'b0;
      pass_nxt    = 1'b0;
      calc_nxt    = calc_q;
      msg_end     = 1'b0;
      msg_pass    = 1'b0;

      if (byte_valid_i) begin
         if (start_i) begin
            // A start byte always wins, even over a terminating condition.
            sum_nxt  = byte_i;
            recv_nxt = 10'd0;
            ndig_nxt = 2'd0;
            if (byte_i == SOH) begin
               soh_sum_nxt = byte_i;
               state_nxt   = SOH_SEEN;
            end else begin
               state_nxt = BODY;
            end
         end else begin
            case (state)
               IDLE: begin
               end
               BODY, SOH_SEEN, GOT1, GOT10: begin
                  sum_nxt = sum_add;
                  if (byte_i == SOH) begin
                     // Snapshot includes this SOH; it is the value the tag must carry.
                     soh_sum_nxt = sum_add;
                     state_nxt   = SOH_SEEN;
                  end else if (state == SOH_SEEN && byte_i == 8'h31) begin
                     state_nxt = GOT1;
                  end else if (state == GOT1 && byte_i == 8'h30) begin
                     state_nxt = GOT10;
                  end else if (state == GOT10 && byte_i == 8'h3D) begin
                     state_nxt = DIG;
                  end else begin
                     state_nxt = BODY;
                  end
               end
               DIG: begin
                  if (is_digit && ndig != 2'd3) begin
                     recv_nxt = recv * 10'd10 + digit_val;
                     ndig_nxt = ndig + 2'd1;
                     if (ndig == 2'd2)
                        state_nxt = TERM;
                  end else begin
                     // Early SOH or any non-digit is a malformed tag.
                     msg_end = 1'b1;
                  end
               end
               TERM: begin
                  msg_end  = 1'b1;
                  msg_pass = (byte_i == SOH) && (recv == {2'b00, soh_sum});
               end
               default: state_nxt = IDLE;
            endcase

            if (msg_end) begin
               done_nxt  = 1'b1;
               pass_nxt  = msg_pass;
               calc_nxt  = soh_sum;
               state_nxt = IDLE;
               sum_nxt   = 8'd0;
               recv_nxt  = 10'd0;
               ndig_nxt  = 2'd0;
            end
         end
      end
   end

   // Outputs come straight from registers
   always_comb begin
      chk_done_o = done_q;
      valid_o    = pass_q;
      calc_o     = calc_q;
   end

endmodule

// File: tb/tb_fix_checksum.sv
// tb_fix_checksum: directed self-checking bench for fix_checksum.
// Latency: outputs are sampled 1 time unit after the edge that accepts each byte.
// Backpressure: none; stimulus presents one byte per call and idles between calls as needed.
module tb_fix_checksum;

   localparam logic [7:0] SOH = 8'h01;

   logic       clk;
   logic       rst;
   logic       byte_valid;
   logic [7:0] byte_in;
   logic       start;
   logic       done;
   logic       valid;
   logic [7:0] calc;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cnt0;

   fix_checksum #(.SOH(SOH)) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid_i (byte_valid),
      .byte_i       (byte_in),
      .start_i      (start),
      .chk_done_o   (done),
      .valid_o      (valid),
      .calc_o       (calc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles in which the done pulse is high.
   always @(posedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic s);
      byte_valid = 1'b1;
      byte_in    = b;
      start      = s;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      start      = 1'b0;
      byte_in    = 8'h00;
   endtask

   task automatic send_str(input string str);
      for (int i = 0; i < str.len(); i++) send(str[i], 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      start      = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk1("reset_done", done, 1'b0);
      chk1("reset_valid", valid, 1'b0);
      chk8("reset_calc", calc, 8'h00);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(1);

      // Basic pass: A SOH 10=066 SOH, snapshot 0x42 = 66
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=066");
      chk1("basic_pre_done", done, 1'b0);
      send(SOH, 1'b0);
      chk1("basic_done", done, 1'b1);
      chk1("basic_valid", valid, 1'b1);
      chk8("basic_calc", calc, 8'h42);
      idle(1);
      chk1("pulse_width_done", done, 1'b0);
      chk1("pulse_width_valid", valid, 1'b0);
      chk8("calc_held", calc, 8'h42);

      // Mismatch: digits 067
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=067");
      send(SOH, 1'b0);
      chk1("mismatch_done", done, 1'b1);
      chk1("mismatch_valid", valid, 1'b0);
      chk8("mismatch_calc", calc, 8'h42);

      // Wrap with gaps, starting right after the mismatch terminator.
      // FF + 04 + SOH = 0x104 -> 0x04
      send(8'hFF, 1'b1);
      idle(2);
      send(8'h04, 1'b0);
      idle(1);
      send(SOH, 1'b0);
      idle(3);
      chk1("gap_done", done, 1'b0);
      chk1("gap_valid", valid, 1'b0);
      chk8("gap_calc", calc, 8'h42);
      send_str("10=");
      idle(1);
      send_str("004");
      idle(2);
      send(SOH, 1'b0);
      chk1("wrap_done", done, 1'b1);
      chk1("wrap_valid", valid, 1'b1);
      chk8("wrap_calc", calc, 8'h04);

      // False tag and repeated SOH: 41+01+31+31+01+01 = 0xA6 = 166
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("11");
      send(SOH, 1'b0);
      send(SOH, 1'b0);
      send_str("10=166");
      send(SOH, 1'b0);
      chk1("falsetag_done", done, 1'b1);
      chk1("falsetag_valid", valid, 1'b1);
      chk8("falsetag_calc", calc, 8'hA6);

      // Too few digits before SOH
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=66");
      send(SOH, 1'b0);
      chk1("short_done", done, 1'b1);
      chk1("short_valid", valid, 1'b0);
      chk8("short_calc", calc, 8'h42);

      // Fourth digit instead of SOH
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=066");
      chk1("long_pre_done", done, 1'b0);
      send(8'h36, 1'b0);
      chk1("long_done", done, 1'b1);
      chk1("long_valid", valid, 1'b0);

      // Non-digit in the tag
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=x");
      chk1("nondigit_done", done, 1'b1);
      chk1("nondigit_valid", valid, 1'b0);

      // Start coincides with terminating SOH: no pulse; new message sum = 01
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=066");
      send(SOH, 1'b1);
      chk1("start_wins_done", done, 1'b0);
      send_str("10=001");
      send(SOH, 1'b0);
      chk1("start_wins_next_done", done, 1'b1);
      chk1("start_wins_next_valid", valid, 1'b1);
      chk8("start_wins_next_calc", calc, 8'h01);

      // Abort during digits, then a full valid message
      idle(1);
      cnt0 = done_cnt;
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=0");
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=066");
      send(SOH, 1'b0);
      chk1("abort_valid", valid, 1'b1);
      chk8("abort_calc", calc, 8'h42);
      idle(1);
      chk8("abort_pulses", 8'(done_cnt - cnt0), 8'd1);

      // Asynchronous reset while the done pulse is high
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=066");
      send(SOH, 1'b0);
      chk1("pre_rst_done", done, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk1("async_rst_done", done, 1'b0);
      chk1("async_rst_valid", valid, 1'b0);
      chk8("async_rst_calc", calc, 8'h00);
      @(posedge clk);
      #1 rst = 1'b1;

      // Reset mid-message, then bytes without start are ignored
      cnt0 = done_cnt;
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=06");
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      send(8'h36, 1'b0);
      send(SOH, 1'b0);
      send_str("10=066");
      send(SOH, 1'b0);
      idle(1);
      chk8("midrst_pulses", 8'(done_cnt - cnt0), 8'd0);
      chk1("ignored_done", done, 1'b0);
      chk8("ignored_calc", calc, 8'h00);

      // Recovery after reset
      send(8'h41, 1'b1);
      send(SOH, 1'b0);
      send_str("10=066");
      send(SOH, 1'b0);
      chk1("recover_done", done, 1'b1);
      chk1("recover_valid", valid, 1'b1);
      chk8("recover_calc", calc, 8'h42);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
